// File: rtl/multi_lane_step_counter_pkg.sv
// Shared types and helpers for the multi-lane step counter.
package counter_pkg;

    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } bound_mode_e;

    function automatic logic in_range(input int val, input int lo, input int hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/multi_lane_step_counter_lane.sv
// One signed up/down step counter lane: load > step > hold, wrap/saturate, INV skip.
module step_counter_lane
    import counter_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int RST_VAL = -50,
    parameter int STEP_UP = 5,
    parameter int STEP_DN = 9,
    parameter int MIN_VAL = -230,
    parameter int MAX_VAL = 235,
    parameter int INV_VAL = -11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    dir_i,
    input  bound_mode_e             mode_i,
    input  logic                    load_i,
    input  logic signed [WIDTH-1:0] load_val_i,
    output logic signed [WIDTH-1:0] cnt_o,
    output logic                    bound_evt_o,
    output logic                    load_err_o
);

    // Two guard bits keep cnt +/- step free of intermediate overflow.
    localparam int EW = WIDTH + 2;
    localparam logic signed [EW-1:0] MAX_E   = EW'(MAX_VAL);
    localparam logic signed [EW-1:0] MIN_E   = EW'(MIN_VAL);
    localparam logic signed [EW-1:0] INV_E   = EW'(INV_VAL);
    localparam logic signed [EW-1:0] UP_E    = EW'(STEP_UP);
    localparam logic signed [EW-1:0] DN_E    = EW'(STEP_DN);
    localparam logic signed [EW-1:0] RANGE_E = EW'(MAX_VAL - MIN_VAL + 1);
    localparam logic signed [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
    localparam logic signed [WIDTH-1:0] INV_W = WIDTH'(INV_VAL);

    logic signed [WIDTH-1:0] cnt_q, cnt_d;
    logic                    bevt_q, bevt_d;
    logic                    lerr_q, lerr_d;
    logic signed [EW-1:0]    cnt_ext;
    logic signed [EW-1:0]    cand;
    logic signed [EW-1:0]    bounded;
    dir_e                    dir;

    assign cnt_ext = {{2{cnt_q[WIDTH-1]}}, cnt_q};
    assign dir     = dir_e'(dir_i);

    always_comb begin
        cnt_d   = cnt_q;
        bevt_d  = 1'b0;
        lerr_d  = 1'b0;
        cand    = (dir == DIR_UP) ? cnt_ext + UP_E : cnt_ext - DN_E;
        bounded = cand;

        if (cand > MAX_E) begin
            bounded = (mode_i == SAT) ? MAX_E : cand - RANGE_E;
        end else if (cand < MIN_E) begin
            bounded = (mode_i == SAT) ? MIN_E : cand + RANGE_E;
        end
        // INV skip is checked after bounding so a wrapped result can also skip.
        if (bounded == INV_E) begin
            bounded = (dir == DIR_UP) ? INV_E + UP_E : INV_E - DN_E;
        end

        if (load_i) begin
            if (in_range(int'(load_val_i), MIN_VAL, MAX_VAL) && (load_val_i != INV_W)) begin
                cnt_d = load_val_i;
            end else begin
                lerr_d = 1'b1;
            end
        end else if (en_i) begin
            cnt_d  = bounded[WIDTH-1:0];
            bevt_d = (cand > MAX_E) || (cand < MIN_E);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= RST_W;
            bevt_q <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bevt_q <= bevt_d;
            lerr_q <= lerr_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign bound_evt_o = bevt_q;
    assign load_err_o  = lerr_q;

endmodule

// File: rtl/multi_lane_step_counter.sv
// NUM_CH independent step counter lanes sharing one range configuration.
module multi_lane_step_counter
    import counter_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int WIDTH   = 10,
    parameter int RST_VAL = -50,
    parameter int STEP_UP = 5,
    parameter int STEP_DN = 9,
    parameter int MIN_VAL = -230,
    parameter int MAX_VAL = 235,
    parameter int INV_VAL = -11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       dir,
    input  logic                    sat_mode,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    output logic [NUM_CH*WIDTH-1:0] cnt,
    output logic [NUM_CH-1:0]       bound_evt,
    output logic [NUM_CH-1:0]       load_err
);

    localparam int LIM_HI = (2 ** (WIDTH - 1)) - 1;
    localparam int LIM_LO = -(2 ** (WIDTH - 1));

    if (!(MIN_VAL < RST_VAL && RST_VAL < MAX_VAL)) begin : g_chk_rst
        $error("RST_VAL must lie strictly between MIN_VAL and MAX_VAL");
    end
    if (INV_VAL == RST_VAL || INV_VAL == MIN_VAL || INV_VAL == MAX_VAL) begin : g_chk_inv
        $error("INV_VAL must differ from RST_VAL, MIN_VAL and MAX_VAL");
    end
    if (INV_VAL - STEP_DN < MIN_VAL || INV_VAL + STEP_UP > MAX_VAL) begin : g_chk_skip
        $error("stepping past INV_VAL must stay inside MIN_VAL..MAX_VAL");
    end
    if (!in_range(STEP_UP, 1, MAX_VAL - MIN_VAL) || !in_range(STEP_DN, 1, MAX_VAL - MIN_VAL)) begin : g_chk_step
        $error("STEP_UP and STEP_DN must lie in 1..(MAX_VAL-MIN_VAL)");
    end
    if (!in_range(RST_VAL, LIM_LO, LIM_HI) || !in_range(MIN_VAL, LIM_LO, LIM_HI) ||
        !in_range(MAX_VAL, LIM_LO, LIM_HI) || !in_range(INV_VAL, LIM_LO, LIM_HI)) begin : g_chk_width
        $error("counter values must fit in WIDTH signed bits");
    end

    bound_mode_e mode;
    assign mode = sat_mode ? SAT : WRAP;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        step_counter_lane #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL),
            .STEP_UP (STEP_UP),
            .STEP_DN (STEP_DN),
            .MIN_VAL (MIN_VAL),
            .MAX_VAL (MAX_VAL),
            .INV_VAL (INV_VAL)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .en_i        (en[i]),
            .dir_i       (dir[i]),
            .mode_i      (mode),
            .load_i      (load[i]),
            .load_val_i  (load_val[i*WIDTH +: WIDTH]),
            .cnt_o       (cnt[i*WIDTH +: WIDTH]),
            .bound_evt_o (bound_evt[i]),
            .load_err_o  (load_err[i])
        );
    end

endmodule

// File: tb/tb_multi_lane_step_counter.sv
// Bench for multi_lane_step_counter: directed spec scenarios plus random traffic vs an arithmetic model.
module tb_multi_lane_step_counter;

    localparam int W    = 10;
    localparam int NCH  = 2;
    localparam int RSTV = -50;
    localparam int SU   = 5;
    localparam int SD   = 9;
    localparam int MINV = -230;
    localparam int MAXV = 235;
    localparam int INV  = -11;
    localparam int R    = MAXV - MINV + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    en, dir, load;
    logic              sat_mode;
    logic [NCH*W-1:0]  load_val;
    logic [NCH*W-1:0]  cnt;
    logic [NCH-1:0]    bound_evt, load_err;

    int passed = 0;
    int total  = 0;
    int mcnt[NCH];
    int mb[NCH];
    int ml[NCH];

    always #5 clk = ~clk;

    multi_lane_step_counter #(
        .NUM_CH (NCH), .WIDTH (W), .RST_VAL (RSTV), .STEP_UP (SU),
        .STEP_DN (SD), .MIN_VAL (MINV), .MAX_VAL (MAXV), .INV_VAL (INV)
    ) dut (
        .clk (clk), .rst_n (rst_n), .en (en), .dir (dir), .sat_mode (sat_mode),
        .load (load), .load_val (load_val), .cnt (cnt),
        .bound_evt (bound_evt), .load_err (load_err)
    );

    function automatic int lane_cnt(input int i);
        logic signed [W-1:0] s;
        s = cnt[i*W +: W];
        return int'(s);
    endfunction

    // Reference step: plain integer arithmetic with modulo wrap or clamp.
    function automatic int m_step(input int c, input bit up, input bit sat, output int evt);
        int n;
        n   = up ? c + SU : c - SD;
        evt = 0;
        if (n > MAXV || n < MINV) begin
            evt = 1;
            if (sat) n = (n > MAXV) ? MAXV : MINV;
            else     n = MINV + (((n - MINV) % R) + R) % R;
        end
        if (n == INV) n = up ? n + SU : n - SD;
        return n;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk0(input string tag, input int c, input int b, input int le);
        chk(tag, lane_cnt(0), c);
        chk({tag, "_evt"}, int'(bound_evt[0]), b);
        chk({tag, "_lerr"}, int'(load_err[0]), le);
    endtask

    task automatic cyc(input logic [NCH-1:0] e, input logic [NCH-1:0] d, input logic [NCH-1:0] l,
                       input int v0, input int v1, input logic s);
        int v[NCH];
        v[0] = v0;
        v[1] = v1;
        en = e; dir = d; load = l; sat_mode = s;
        load_val = {W'(v1), W'(v0)};
        @(posedge clk);
        for (int i = 0; i < NCH; i++) begin
            mb[i] = 0;
            ml[i] = 0;
            if (l[i]) begin
                if (v[i] >= MINV && v[i] <= MAXV && v[i] != INV) mcnt[i] = v[i];
                else ml[i] = 1;
            end else if (e[i]) begin
                mcnt[i] = m_step(mcnt[i], d[i], s, mb[i]);
            end
        end
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("cnt%0d", i), lane_cnt(i), mcnt[i]);
            chk($sformatf("bevt%0d", i), int'(bound_evt[i]), mb[i]);
            chk($sformatf("lerr%0d", i), int'(load_err[i]), ml[i]);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = '0; dir = '0; load = '0; sat_mode = 1'b0; load_val = '0;
        for (int i = 0; i < NCH; i++) begin mcnt[i] = RSTV; mb[i] = 0; ml[i] = 0; end
        repeat (2) @(negedge clk);
        chk0("rst", RSTV, 0, 0);
        chk("rst_cnt1", lane_cnt(1), RSTV);
        rst_n = 1'b1;

        // Upward run across the forbidden value
        cyc(2'b01, 2'b01, 2'b00, 0, 0, 1'b0);   chk0("up1", -45, 0, 0);
        cyc(2'b00, 2'b01, 2'b01, -21, 0, 1'b0); chk0("ld_m21", -21, 0, 0);
        cyc(2'b01, 2'b01, 2'b00, 0, 0, 1'b0);   chk0("up_m16", -16, 0, 0);
        cyc(2'b01, 2'b01, 2'b00, 0, 0, 1'b0);   chk0("up_skip", -6, 0, 0);
        cyc(2'b01, 2'b01, 2'b00, 0, 0, 1'b0);   chk0("up_m1", -1, 0, 0);

        // Load then downward run across the forbidden value; lane 1 idle
        cyc(2'b00, 2'b00, 2'b01, -2, 0, 1'b0);  chk0("ld_m2", -2, 0, 0);
        cyc(2'b01, 2'b00, 2'b00, 0, 0, 1'b0);   chk0("dn_skip", -20, 0, 0);
        cyc(2'b01, 2'b00, 2'b00, 0, 0, 1'b0);   chk0("dn_m29", -29, 0, 0);
        chk("hold1", lane_cnt(1), RSTV);

        // Wrap mode
        cyc(2'b00, 2'b00, 2'b01, 230, 0, 1'b0); chk0("ld_230", 230, 0, 0);
        cyc(2'b01, 2'b01, 2'b00, 0, 0, 1'b0);   chk0("up_max", 235, 0, 0);
        cyc(2'b01, 2'b01, 2'b00, 0, 0, 1'b0);   chk0("wrap_hi", -226, 1, 0);
        cyc(2'b00, 2'b01, 2'b00, 0, 0, 1'b0);   chk0("wrap_hold", -226, 0, 0);
        cyc(2'b00, 2'b00, 2'b01, -225, 0, 1'b0);
        cyc(2'b01, 2'b00, 2'b00, 0, 0, 1'b0);   chk0("wrap_lo", 232, 1, 0);

        // Saturate mode
        cyc(2'b00, 2'b00, 2'b01, -225, 0, 1'b1);
        cyc(2'b01, 2'b00, 2'b00, 0, 0, 1'b1);   chk0("sat1", MINV, 1, 0);
        cyc(2'b01, 2'b00, 2'b00, 0, 0, 1'b1);   chk0("sat2", MINV, 1, 0);
        cyc(2'b01, 2'b00, 2'b00, 0, 0, 1'b1);   chk0("sat3", MINV, 1, 0);
        cyc(2'b01, 2'b01, 2'b00, 0, 0, 1'b1);   chk0("sat_up", -225, 0, 0);

        // Rejected loads block the step
        cyc(2'b01, 2'b01, 2'b01, INV, 0, 1'b0); chk0("rej_inv", -225, 0, 1);
        cyc(2'b00, 2'b01, 2'b00, 0, 0, 1'b0);   chk0("rej_clr", -225, 0, 0);
        cyc(2'b01, 2'b01, 2'b01, 236, 0, 1'b0); chk0("rej_236", -225, 0, 1);
        cyc(2'b11, 2'b10, 2'b11, MINV, MAXV + 5, 1'b0);

        // Asynchronous reset mid-cycle while both lanes count
        en = 2'b11; dir = 2'b11; load = '0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cnt0", lane_cnt(0), RSTV);
        chk("arst_cnt1", lane_cnt(1), RSTV);
        chk("arst_evt", int'(bound_evt), 0);
        chk("arst_lerr", int'(load_err), 0);
        for (int i = 0; i < NCH; i++) begin mcnt[i] = RSTV; mb[i] = 0; ml[i] = 0; end
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2'b11, 2'b11, 2'b00, 0, 0, 1'b0);   chk0("resume", -45, 0, 0);

        // Random traffic against the model
        for (int k = 0; k < 500; k++) begin
            logic [NCH-1:0] re, rd, rl;
            int rv[NCH];
            logic rs;
            re = NCH'($urandom);
            rd = NCH'($urandom);
            rl = '0;
            for (int i = 0; i < NCH; i++) begin
                rl[i] = ($urandom_range(7) == 0);
                rv[i] = int'($urandom_range(540)) - 270;
                if ($urandom_range(9) == 0) rv[i] = INV;
            end
            rs = ($urandom_range(3) == 0);
            cyc(re, rd, rl, rv[0], rv[1], rs);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
